// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Package name is rf_pkg; it is imported by every regfile_mp file.
package rf_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          NREG_DEF    = 32;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

    // Widest flattened bus and widest single field the slice helper handles.
    localparam int FLAT_W  = 512;
    localparam int SLICE_W = 128;

    // Extracts field idx of width w from a flattened port bus.
    function automatic logic [SLICE_W-1:0] get_slice(
        input logic [FLAT_W-1:0] flat,
        input int                idx,
        input int                w
    );
        logic [FLAT_W-1:0] mask;
        mask = (FLAT_W'(1) << w) - FLAT_W'(1);
        return SLICE_W'((flat >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file: read, busy query/set,
// write ports and the debug read.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-producer bits; a new busy_set outranks a same-cycle
// write clear so the newest producer is tracked.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            set_i,
    input  logic [AW-1:0]   set_addr_i,
    input  logic [NREG-1:0] clr_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_vec;

    always_comb begin
        set_vec = '0;
        if (set_i && (set_addr_i != '0)) begin
            set_vec[set_addr_i] = 1'b1;
        end
        busy_d = (busy_q & ~clr_i) | set_vec;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional
// write-to-read bypass and a busy scoreboard for pending producers.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter int              NREG    = NREG_DEF,
    parameter int              NRD     = 2,
    parameter int              NWR     = 1,
    parameter int              BYPASS  = 1,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF)
) (
    input logic         clk_i,
    input logic         reset_i,
    regfile_mp_if.slave rf_bus
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     regs_q [NREG];
    logic [XLEN-1:0]     regs_d [NREG];
    logic [AW-1:0]       wa [NWR];
    logic [XLEN-1:0]     wd [NWR];
    logic [NWR-1:0]      wv;
    logic [NREG-1:0]     clr_vec;
    logic [NREG-1:0]     busy;
    logic [NRD*XLEN-1:0] rd_data_flat;
    logic [NRD-1:0]      rd_busy_v;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wa[w] = AW'(get_slice(FLAT_W'(rf_bus.wr_addr), w, AW));
            wd[w] = XLEN'(get_slice(FLAT_W'(rf_bus.wr_data), w, XLEN));
            wv[w] = rf_bus.wr_en[w] && (wa[w] != '0);
        end
    end

    // Ascending port order makes the highest-numbered port win a conflict.
    always_comb begin
        regs_d  = regs_q;
        clr_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wv[w]) begin
                regs_d[wa[w]]  = wd[w];
                clr_vec[wa[w]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .set_i      (rf_bus.busy_set),
        .set_addr_i (rf_bus.busy_addr),
        .clr_i      (clr_vec),
        .busy_o     (busy)
    );

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            hit;
        ra           = '0;
        data         = '0;
        hit          = 1'b0;
        rd_data_flat = '0;
        rd_busy_v    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = AW'(get_slice(FLAT_W'(rf_bus.rd_addr), i, AW));
            data = regs_q[ra];
            hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wv[w] && (wa[w] == ra)) begin
                        data = wd[w];
                        hit  = 1'b1;
                    end
                end
            end
            rd_data_flat[i*XLEN +: XLEN] = data;
            rd_busy_v[i]                 = busy[ra] & ~hit;
        end
    end

    assign rf_bus.rd_data  = rd_data_flat;
    assign rf_bus.rd_busy  = rd_busy_v;
    assign rf_bus.dbg_data = regs_q[rf_bus.dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: dut_a is NWR=2 with bypass, dut_b is NWR=1 without.
module tb_regfile_mp;

    logic clk;
    logic reset;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) if_a ();
    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1)) if_b ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk_i   (clk),
        .reset_i (reset),
        .rf_bus  (if_a.slave)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
        .clk_i   (clk),
        .reset_i (reset),
        .rf_bus  (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signal selectors for the monitor.
    localparam int A_RD0 = 0, A_RD1 = 1, A_BSY0 = 2, A_BSY1 = 3, A_DBG = 4;
    localparam int B_RD0 = 5, B_BSY0 = 6, B_DBG = 7;

    int          kind_q [$];
    logic [31:0] exp_q  [$];
    string       tag_q  [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic expect_val(input int kind, input logic [31:0] val, input string tag);
        kind_q.push_back(kind);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            A_RD0:   return if_a.rd_data[31:0];
            A_RD1:   return if_a.rd_data[63:32];
            A_BSY0:  return {31'b0, if_a.rd_busy[0]};
            A_BSY1:  return {31'b0, if_a.rd_busy[1]};
            A_DBG:   return if_a.dbg_data;
            B_RD0:   return if_b.rd_data[31:0];
            B_BSY0:  return {31'b0, if_b.rd_busy[0]};
            B_DBG:   return if_b.dbg_data;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    int          m_kind;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_tag;

    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            m_kind = kind_q.pop_front();
            m_exp  = exp_q.pop_front();
            m_tag  = tag_q.pop_front();
            m_act  = actual(m_kind);
            n_tests++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s (sel %0d): got %h expected %h", m_tag, m_kind, m_act, m_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_a.wr_en    = '0;
        if_a.busy_set = 1'b0;
        if_b.wr_en    = '0;
        if_b.busy_set = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int b0);
        if_a.rd_addr = {5'(a1), 5'(a0)};
        if_b.rd_addr = {5'd0, 5'(b0)};
    endtask

    task automatic set_dbg(input int a, input int b);
        if_a.dbg_addr = 5'(a);
        if_b.dbg_addr = 5'(b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        if_a.rd_addr   = '0;
        if_a.wr_en     = '0;
        if_a.wr_addr   = '0;
        if_a.wr_data   = '0;
        if_a.busy_set  = 1'b0;
        if_a.busy_addr = '0;
        if_a.dbg_addr  = '0;
        if_b.rd_addr   = '0;
        if_b.wr_en     = '0;
        if_b.wr_addr   = '0;
        if_b.wr_data   = '0;
        if_b.busy_set  = 1'b0;
        if_b.busy_addr = '0;
        if_b.dbg_addr  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset contents: only x2 holds the stack pointer.
        for (int r = 0; r < 32; r++) begin
            set_dbg(r, r);
            set_rd(r, r, r);
            expect_val(A_DBG,  (r == 2) ? 32'h0000_2ffc : 32'h0, "reset_dbg_a");
            expect_val(B_DBG,  (r == 2) ? 32'h0000_2ffc : 32'h0, "reset_dbg_b");
            expect_val(A_RD0,  (r == 2) ? 32'h0000_2ffc : 32'h0, "reset_rd_a");
            expect_val(A_BSY0, 32'h0, "reset_busy_a");
            expect_val(B_BSY0, 32'h0, "reset_busy_b");
            tick();
        end

        // Write x5: bypass on A, old value on B, dbg never bypassed.
        if_a.wr_en   = 2'b01;
        if_a.wr_addr = {5'd0, 5'd5};
        if_a.wr_data = {32'h0, 32'hDEAD_BEEF};
        if_b.wr_en   = 1'b1;
        if_b.wr_addr = 5'd5;
        if_b.wr_data = 32'hDEAD_BEEF;
        set_rd(5, 0, 5);
        set_dbg(5, 5);
        expect_val(A_RD0, 32'hDEAD_BEEF, "x5_bypass_a");
        expect_val(B_RD0, 32'h0,         "x5_nobypass_b");
        expect_val(A_DBG, 32'h0,         "x5_dbg_a");
        expect_val(B_DBG, 32'h0,         "x5_dbg_b");
        tick();
        idle();
        expect_val(A_RD0, 32'hDEAD_BEEF, "x5_after_a");
        expect_val(B_RD0, 32'hDEAD_BEEF, "x5_after_b");
        expect_val(B_DBG, 32'hDEAD_BEEF, "x5_dbg_after_b");
        tick();

        // x0 write and busy_set are dropped.
        if_a.wr_en     = 2'b01;
        if_a.wr_addr   = {5'd0, 5'd0};
        if_a.wr_data   = {32'h0, 32'h0000_1234};
        if_a.busy_set  = 1'b1;
        if_a.busy_addr = 5'd0;
        set_rd(0, 0, 0);
        set_dbg(0, 0);
        expect_val(A_RD0,  32'h0, "x0_rd_same");
        expect_val(A_BSY0, 32'h0, "x0_busy_same");
        tick();
        idle();
        expect_val(A_RD0,  32'h0, "x0_rd_after");
        expect_val(A_BSY0, 32'h0, "x0_busy_after");
        expect_val(A_DBG,  32'h0, "x0_dbg_after");
        tick();

        // Both ports write x7: port 1 wins in array and bypass.
        if_a.wr_en   = 2'b11;
        if_a.wr_addr = {5'd7, 5'd7};
        if_a.wr_data = {32'h2, 32'h1};
        set_rd(0, 7, 0);
        set_dbg(7, 0);
        expect_val(A_RD1, 32'h2, "x7_bypass_conflict");
        expect_val(A_DBG, 32'h0, "x7_dbg_same");
        tick();
        idle();
        expect_val(A_RD1, 32'h2, "x7_after");
        expect_val(A_DBG, 32'h2, "x7_dbg_after");
        tick();

        // Scoreboard on x9.
        if_a.busy_set  = 1'b1;
        if_a.busy_addr = 5'd9;
        if_b.busy_set  = 1'b1;
        if_b.busy_addr = 5'd9;
        set_rd(9, 0, 9);
        expect_val(A_BSY0, 32'h0, "x9_busy_setcycle_a");
        expect_val(B_BSY0, 32'h0, "x9_busy_setcycle_b");
        tick();
        idle();
        expect_val(A_BSY0, 32'h1, "x9_busy_a");
        expect_val(B_BSY0, 32'h1, "x9_busy_b");
        tick();
        if_a.wr_en     = 2'b01;
        if_a.wr_addr   = {5'd0, 5'd9};
        if_a.wr_data   = {32'h0, 32'h5};
        if_a.busy_set  = 1'b1;
        if_b.wr_en     = 1'b1;
        if_b.wr_addr   = 5'd9;
        if_b.wr_data   = 32'h5;
        if_b.busy_set  = 1'b1;
        expect_val(A_RD0,  32'h5, "x9_wrset_rd_a");
        expect_val(A_BSY0, 32'h0, "x9_wrset_busy_a");
        expect_val(B_RD0,  32'h0, "x9_wrset_rd_b");
        expect_val(B_BSY0, 32'h1, "x9_wrset_busy_b");
        tick();
        idle();
        expect_val(A_BSY0, 32'h1, "x9_set_wins_a");
        expect_val(B_BSY0, 32'h1, "x9_set_wins_b");
        expect_val(A_RD0,  32'h5, "x9_data_a");
        expect_val(B_RD0,  32'h5, "x9_data_b");
        tick();
        if_a.wr_en = 2'b01;
        if_b.wr_en = 1'b1;
        expect_val(A_BSY0, 32'h0, "x9_clr_same_a");
        expect_val(B_BSY0, 32'h1, "x9_clr_same_b");
        tick();
        idle();
        expect_val(A_BSY0, 32'h0, "x9_clr_a");
        expect_val(B_BSY0, 32'h0, "x9_clr_b");
        expect_val(A_RD0,  32'h5, "x9_final_a");
        expect_val(B_RD0,  32'h5, "x9_final_b");
        tick();

        // Re-arm x9 busy, then reset overrides a write to x3 and busy_set x3.
        if_a.busy_set  = 1'b1;
        if_a.busy_addr = 5'd9;
        tick();
        idle();
        if_a.wr_en     = 2'b01;
        if_a.wr_addr   = {5'd0, 5'd3};
        if_a.wr_data   = {32'h0, 32'h7};
        if_a.busy_set  = 1'b1;
        if_a.busy_addr = 5'd3;
        if_b.wr_en     = 1'b1;
        if_b.wr_addr   = 5'd3;
        if_b.wr_data   = 32'h7;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        set_rd(3, 5, 3);
        set_dbg(2, 5);
        expect_val(A_RD0, 32'h0,         "rst_x3_a");
        expect_val(B_RD0, 32'h0,         "rst_x3_b");
        expect_val(A_RD1, 32'h0,         "rst_x5_a");
        expect_val(A_DBG, 32'h0000_2ffc, "rst_sp_a");
        expect_val(B_DBG, 32'h0,         "rst_x5_b");
        tick();
        for (int r = 0; r < 32; r++) begin
            set_rd(r, 0, r);
            expect_val(A_BSY0, 32'h0, "rst_busy_a");
            expect_val(B_BSY0, 32'h0, "rst_busy_b");
            tick();
        end

        // First post-reset traffic is accepted normally.
        if_b.wr_en   = 1'b1;
        if_b.wr_addr = 5'd4;
        if_b.wr_data = 32'h0000_000B;
        set_rd(0, 0, 4);
        expect_val(B_RD0, 32'h0, "x4_same_b");
        tick();
        idle();
        expect_val(B_RD0, 32'h0000_000B, "x4_after_b");
        tick();

        @(negedge clk);
        #1;
        if (kind_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", kind_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
